// File: rtl/iface_chan_arbiter_if.sv
// Bundle of producer-side and consumer-side signals for the channel arbiter.
// Latency: none (wires only).
// Backpressure: producers see in_ready per channel; the consumer drives out_ready.
interface iface_chan_arbiter_if #(
    parameter int WIDTH = 3,
    parameter int NCHAN = 2,
    parameter int DEPTH = 4
);
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [NCHAN-1:0]       in_valid;
    logic [NCHAN-1:0]       in_ready;
    logic [NCHAN*WIDTH-1:0] in_item;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_item;
    logic [CW-1:0]          out_chan;
    logic [NCHAN*OW-1:0]    occupancy;

    // Environment side: drives producers and the consumer ready.
    modport master (
        output in_valid, in_item, out_ready,
        input  in_ready, out_valid, out_item, out_chan, occupancy
    );

    // Arbiter side.
    modport slave (
        input  in_valid, in_item, out_ready,
        output in_ready, out_valid, out_item, out_chan, occupancy
    );
endinterface

// File: rtl/iface_chan_arbiter.sv
// Per-channel FIFOs merged onto one consumer port with round-robin, stable-grant arbitration.
// Latency: 1 cycle minimum from push edge to out_item (no bypass path).
// Backpressure: in_ready drops when a channel is full; a stalled grant is held until transfer.
module iface_chan_arbiter #(
    parameter int WIDTH = 3,
    parameter int NCHAN = 2,
    parameter int DEPTH = 4,
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int OW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    iface_chan_arbiter_if.slave  bus
);

    // OPEN: grant follows the round-robin scan; HOLD: a stalled grant is frozen.
    typedef enum logic {ST_OPEN, ST_HOLD} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     gnt_q, gnt_d;
    logic [OW-1:0]     occ_q    [NCHAN];
    logic [OW-1:0]     occ_d    [NCHAN];
    logic [PW-1:0]     rd_ptr_q [NCHAN];
    logic [PW-1:0]     rd_ptr_d [NCHAN];
    logic [PW-1:0]     wr_ptr_q [NCHAN];
    logic [PW-1:0]     wr_ptr_d [NCHAN];
    logic [WIDTH-1:0]  mem_q    [NCHAN][DEPTH];

    logic [NCHAN-1:0]  push;
    logic [NCHAN-1:0]  pop;
    logic [NCHAN-1:0]  nonempty;
    logic              any_vld;
    logic [CW-1:0]     scan_gnt;
    logic [CW-1:0]     gnt;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        // in_ready depends only on state and reset, never on valid or out_ready.
        assign bus.in_ready[g]              = !reset && (occ_q[g] != OW'(DEPTH));
        assign push[g]                      = bus.in_valid[g] && bus.in_ready[g];
        assign nonempty[g]                  = (occ_q[g] != '0);
        assign pop[g]                       = any_vld && bus.out_ready && (gnt == CW'(g));
        assign bus.occupancy[g*OW +: OW]    = occ_q[g];
    end

    assign any_vld       = |nonempty;
    assign gnt           = (state_q == ST_HOLD) ? gnt_q : scan_gnt;
    assign bus.out_valid = any_vld;
    assign bus.out_chan  = any_vld ? gnt : '0;
    assign bus.out_item  = any_vld ? mem_q[gnt][rd_ptr_q[gnt]] : '0;

    // Round-robin scan: first non-empty channel starting at rr_ptr, wrapping.
    always_comb begin
        int  idx;
        logic found;
        scan_gnt = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NCHAN; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NCHAN) idx = idx - NCHAN;
            if (!found && nonempty[idx]) begin
                found    = 1'b1;
                scan_gnt = CW'(idx);
            end
        end
    end

    // Next-state: FIFO pointers/occupancy, grant-lock FSM and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        for (int i = 0; i < NCHAN; i++) begin
            occ_d[i]    = occ_q[i] + OW'(push[i]) - OW'(pop[i]);
            wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PW'(1) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PW'(1) : rd_ptr_q[i];
        end
        case (state_q)
            ST_OPEN: begin
                if (any_vld && !bus.out_ready) begin
                    state_d = ST_HOLD;
                    gnt_d   = scan_gnt;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) state_d = ST_OPEN;
            end
            default: state_d = ST_OPEN;
        endcase
        if (any_vld && bus.out_ready) begin
            rr_ptr_d = (gnt == CW'(NCHAN - 1)) ? '0 : gnt + CW'(1);
        end
    end

    // State register with synchronous reset; discards all buffered items.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_OPEN;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            for (int i = 0; i < NCHAN; i++) begin
                occ_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            for (int i = 0; i < NCHAN; i++) begin
                occ_q[i]    <= occ_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
            end
        end
    end

    // FIFO storage write; push is already blocked during reset via in_ready.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCHAN; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= bus.in_item[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_iface_chan_arbiter.sv
// Self-checking bench for iface_chan_arbiter against a queue-based reference model.
// Latency: model compares every cycle, sampling #1 after the falling edge.
// Backpressure: directed stall/full scenarios followed by randomized traffic.
module tb_iface_chan_arbiter;
    localparam int WIDTH = 3;
    localparam int NCHAN = 2;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    iface_chan_arbiter_if #(.WIDTH(WIDTH), .NCHAN(NCHAN), .DEPTH(DEPTH)) bus ();

    iface_chan_arbiter #(.WIDTH(WIDTH), .NCHAN(NCHAN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: one queue per channel, next-priority channel, held channel (-1 = none).
    int q [NCHAN][$];
    int rr;
    int held;
    bit fresh;
    int checks;
    int errors;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick();
        if (held >= 0) return held;
        for (int k = 0; k < NCHAN; k++) begin
            int c;
            c = (rr + k) % NCHAN;
            if (q[c].size() > 0) return c;
        end
        return -1;
    endfunction

    task automatic step(input bit rst, input bit [NCHAN-1:0] v,
                        input int it0, input int it1, input bit rdy);
        int c;
        int its [NCHAN];
        int sz  [NCHAN];
        logic [NCHAN*WIDTH-1:0] pk;
        its[0] = it0 % (1 << WIDTH);
        its[1] = it1 % (1 << WIDTH);
        for (int i = 0; i < NCHAN; i++) pk[i*WIDTH +: WIDTH] = WIDTH'(its[i]);
        @(negedge clk);
        reset         = rst;
        bus.in_valid  = v;
        bus.in_item   = pk;
        bus.out_ready = rdy;
        #1;
        c = pick();
        check_eq("out_valid", int'(bus.out_valid), (c >= 0) ? 1 : 0);
        if (c >= 0) begin
            check_eq("out_chan", int'(bus.out_chan), c);
            check_eq("out_item", int'(bus.out_item), q[c][0]);
        end else if (fresh) begin
            check_eq("out_chan_rst", int'(bus.out_chan), 0);
            check_eq("out_item_rst", int'(bus.out_item), 0);
        end
        for (int i = 0; i < NCHAN; i++) begin
            sz[i] = q[i].size();
            check_eq($sformatf("occupancy%0d", i), int'(bus.occupancy[i*OW +: OW]), sz[i]);
            check_eq($sformatf("in_ready%0d", i), int'(bus.in_ready[i]),
                     (!rst && sz[i] != DEPTH) ? 1 : 0);
        end
        // Advance the model across the coming rising edge.
        if (rst) begin
            for (int i = 0; i < NCHAN; i++) q[i].delete();
            rr    = 0;
            held  = -1;
            fresh = 1'b1;
        end else begin
            if (c >= 0) begin
                fresh = 1'b0;
                if (rdy) begin
                    void'(q[c].pop_front());
                    rr   = (c + 1) % NCHAN;
                    held = -1;
                end else begin
                    held = c;
                end
            end
            for (int i = 0; i < NCHAN; i++)
                if (v[i] && sz[i] < DEPTH) q[i].push_back(its[i]);
        end
    endtask

    initial begin
        int bias;
        checks = 0;
        errors = 0;
        rr     = 0;
        held   = -1;
        fresh  = 1'b1;
        reset  = 1'b1;
        bus.in_valid  = '0;
        bus.in_item   = '0;
        bus.out_ready = 1'b0;

        // Reset, then the first cycle after release.
        step(1, 2'b00, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0);

        // Single item on ch0, then pop.
        step(0, 2'b01, 5, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 0, 0, 1);
        step(0, 2'b00, 0, 0, 0);

        // Fill ch1 with a stalled consumer; fifth push must be ignored.
        for (int k = 0; k < 5; k++) step(0, 2'b10, 0, k + 1, 0);
        step(0, 2'b00, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 2'b00, 0, 0, 1);

        // Alternation with per-channel ordering: expect 1,6,2,7.
        step(0, 2'b11, 1, 6, 0);
        step(0, 2'b11, 2, 7, 0);
        for (int k = 0; k < 5; k++) step(0, 2'b00, 0, 0, 1);

        // Stable grant on ch1 while ch0 fills, then ch0 is next.
        step(0, 2'b10, 0, 3, 1);
        step(0, 2'b00, 0, 0, 1);
        step(0, 2'b10, 0, 3, 0);
        step(0, 2'b01, 4, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 0, 0, 1);
        step(0, 2'b00, 0, 0, 1);
        step(0, 2'b00, 0, 0, 0);

        // Simultaneous push and pop on ch0 at occupancy 2.
        step(0, 2'b01, 1, 0, 0);
        step(0, 2'b01, 2, 0, 0);
        step(0, 2'b01, 3, 0, 1);
        for (int k = 0; k < 4; k++) step(0, 2'b00, 0, 0, 1);

        // Full channels, full-and-popped push attempt, then reset mid-operation.
        for (int k = 0; k < 4; k++) step(0, 2'b11, k, k + 4, 0);
        step(0, 2'b11, 7, 7, 1);
        step(0, 2'b11, 6, 6, 0);
        step(1, 2'b11, 1, 1, 1);
        step(0, 2'b00, 0, 0, 0);

        // Randomized traffic with varying consumer pressure and rare resets.
        for (int n = 0; n < 3000; n++) begin
            bias = (n / 500) % 3;
            step(($urandom_range(0, 199) == 0),
                 NCHAN'($urandom),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)),
                 (bias == 0) ? ($urandom_range(0, 3) == 0)
                 : (bias == 1) ? ($urandom_range(0, 1) == 0)
                 : ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
